// File: rtl/oclib_async_serial_tx_arbiter_pkg.sv
// Local types and sizing helpers for the async serial TX arbiter.
package oclib_async_serial_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Bit counter must hold the largest "bits remaining" value plus headroom.
    function automatic int unsigned count_width(input int unsigned total_bits);
        return $clog2(total_bits) + 1;
    endfunction

endpackage

// File: rtl/oclib_pkg.sv
// Library-wide constants shared across oclib blocks.
package oclib_pkg;

    localparam bit False = 1'b0;
    localparam bit True  = 1'b1;

endpackage

// File: rtl/oclib_module_reset.sv
// Optional reset synchronization followed by optional pipeline stages.
module oclib_module_reset #(
    parameter bit          ResetSync     = 1'b0,
    parameter int unsigned SyncCycles    = 3,
    parameter int unsigned ResetPipeline = 0
) (
    input  logic clock,
    input  logic reset_in,
    output logic reset_out
);

    logic synced;

    if (ResetSync) begin : g_sync
        oclib_synchronizer #(
            .Width      (1),
            .SyncCycles (SyncCycles)
        ) u_sync (
            .clock (clock),
            .din   (reset_in),
            .dout  (synced)
        );
    end else begin : g_nosync
        assign synced = reset_in;
    end

    if (ResetPipeline > 0) begin : g_pipe
        logic [ResetPipeline-1:0] pipe_q;

        always_ff @(posedge clock) begin
            pipe_q[0] <= synced;
            for (int i = 1; i < int'(ResetPipeline); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign reset_out = pipe_q[ResetPipeline-1];
    end else begin : g_nopipe
        assign reset_out = synced;
    end

endmodule

// File: rtl/oclib_rr_picker.sv
// Round-robin picker: first set request searching upward from last+1, wrapping.
module oclib_rr_picker #(
    parameter int unsigned Requesters = 2
) (
    input  logic [Requesters-1:0]         req,
    input  logic [$clog2(Requesters)-1:0] last,
    output logic [$clog2(Requesters)-1:0] grant,
    output logic                          any
);

    localparam int unsigned IdxW = $clog2(Requesters);

    logic [IdxW-1:0] cand;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= Requesters; i++) begin
            cand = IdxW'((32'(last) + i) % Requesters);
            if (!any && req[cand]) begin
                grant = cand;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/oclib_synchronizer.sv
// Multi-flop synchronizer for signals crossing into the clock domain.
module oclib_synchronizer #(
    parameter int unsigned Width      = 1,
    parameter int unsigned SyncCycles = 3
) (
    input  logic             clock,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout
);

    logic [Width-1:0] stage_q [SyncCycles];

    always_ff @(posedge clock) begin
        stage_q[0] <= din;
        for (int i = 1; i < int'(SyncCycles); i++) begin
            stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[SyncCycles-1];

endmodule

// File: rtl/oclib_async_serial_tx_arbiter.sv
// Round-robin arbiter feeding a toggle-encoded, ack-paced serial link.
// Define OCLIB_ASYNC_SERIAL_ARB_ID_EN to prefix each word with the source ID.
module oclib_async_serial_tx_arbiter
    import oclib_async_serial_tx_arbiter_pkg::*;
#(
    parameter int unsigned Requesters    = 2,
    parameter int unsigned Width         = 8,
    parameter int unsigned SyncCycles    = 3,
    parameter bit          ResetSync     = oclib_pkg::False,
    parameter int unsigned ResetPipeline = 0
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [Requesters-1:0][Width-1:0]   inData,
    input  logic [Requesters-1:0]              inValid,
    output logic [Requesters-1:0]              inReady,
    output logic [1:0]                         outData,
    input  logic                               outAck
);

    localparam int unsigned IdxW = $clog2(Requesters);
`ifdef OCLIB_ASYNC_SERIAL_ARB_ID_EN
    localparam int unsigned IdBits = IdxW;
`else
    localparam int unsigned IdBits = 0;
`endif
    localparam int unsigned TotalBits = Width + IdBits;
    localparam int unsigned CntW      = count_width(TotalBits);

    logic reset_int;
    logic ack_sync;
    logic [IdxW-1:0] pick_idx;
    logic pick_any;

    state_e state_q, state_d;
    logic [1:0] out_data_q, out_data_d;
    logic [TotalBits-1:0] shift_q, shift_d;
    logic [CntW-1:0] bit_count_q, bit_count_d;
    logic [IdxW-1:0] last_grant_q, last_grant_d;
    logic [Requesters-1:0] in_ready_c;

    oclib_module_reset #(
        .ResetSync     (ResetSync),
        .SyncCycles    (SyncCycles),
        .ResetPipeline (ResetPipeline)
    ) u_reset (
        .clock     (clock),
        .reset_in  (reset),
        .reset_out (reset_int)
    );

    oclib_synchronizer #(
        .Width      (1),
        .SyncCycles (SyncCycles)
    ) u_ack_sync (
        .clock (clock),
        .din   (outAck),
        .dout  (ack_sync)
    );

    oclib_rr_picker #(
        .Requesters (Requesters)
    ) u_picker (
        .req   (inValid),
        .last  (last_grant_q),
        .grant (pick_idx),
        .any   (pick_any)
    );

    // Ready is a same-cycle grant strobe so the source sees it on the capture edge.
    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        shift_d      = shift_q;
        bit_count_d  = bit_count_q;
        last_grant_d = last_grant_q;
        in_ready_c   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    in_ready_c[pick_idx] = !reset_int;
`ifdef OCLIB_ASYNC_SERIAL_ARB_ID_EN
                    shift_d = {inData[pick_idx], pick_idx};
`else
                    shift_d = inData[pick_idx];
`endif
                    bit_count_d  = CntW'(TotalBits - 1);
                    last_grant_d = pick_idx;
                    state_d      = ST_SEND;
                end
            end
            ST_SEND: begin
                if (shift_q[0]) begin
                    out_data_d[1] = ~out_data_q[1];
                end else begin
                    out_data_d[0] = ~out_data_q[0];
                end
                shift_d = shift_q >> 1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The receiver echoes link parity once it has consumed the bit.
                if (ack_sync == ^out_data_q) begin
                    if (bit_count_q != '0) begin
                        bit_count_d = bit_count_q - CntW'(1);
                        state_d     = ST_SEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset_int) begin
            state_q      <= ST_IDLE;
            out_data_q   <= 2'b00;
            shift_q      <= '0;
            bit_count_q  <= '0;
            last_grant_q <= IdxW'(Requesters - 1);
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            shift_q      <= shift_d;
            bit_count_q  <= bit_count_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign inReady = in_ready_c;
    assign outData = out_data_q;

endmodule

// File: tb/tb_oclib_async_serial_tx_arbiter.sv
// Directed bench: looped-back receiver model, link/grant monitor, assertion checks.
module tb_oclib_async_serial_tx_arbiter;

    localparam int NREQ = 3;
`ifdef OCLIB_ASYNC_SERIAL_ARB_ID_EN
    localparam int IDB = 2;
`else
    localparam int IDB = 0;
`endif
    localparam int WB = 8 + IDB;

    logic clk = 1'b0;
    logic reset;
    logic [NREQ-1:0][7:0] in_data;
    logic [NREQ-1:0] in_valid;
    logic [NREQ-1:0] in_ready;
    logic [1:0] out_data;
    logic out_ack;

    logic ack_freeze;
    logic [3:0] ack_pipe;

    int n_cmp = 0;
    int n_err = 0;
    int viol = 0;
    int bits_q[$];
    int grants_q[$];
    int gpos_q[$];
    logic [1:0] prev_od = 2'b00;

    always #5 clk = ~clk;

    oclib_async_serial_tx_arbiter #(
        .Requesters (NREQ),
        .Width      (8),
        .SyncCycles (3)
    ) dut (
        .clock   (clk),
        .reset   (reset),
        .inData  (in_data),
        .inValid (in_valid),
        .inReady (in_ready),
        .outData (out_data),
        .outAck  (out_ack)
    );

    // Receiver: echoes link parity about four cycles later unless frozen.
    always @(posedge clk) begin
        if (reset) begin
            ack_pipe <= '0;
            out_ack  <= 1'b0;
        end else begin
            ack_pipe <= {ack_pipe[2:0], ^out_data};
            if (!ack_freeze) out_ack <= ack_pipe[3];
        end
    end

    // Decode toggles into bits and log grants.
    always @(negedge clk) begin
        int gi;
        if (reset) begin
            prev_od = out_data;
        end else begin
            if (out_data != prev_od) begin
                case (out_data ^ prev_od)
                    2'b01:   bits_q.push_back(0);
                    2'b10:   bits_q.push_back(1);
                    default: bits_q.push_back(9);
                endcase
                if (out_ack !== ^prev_od) viol++;
            end
            prev_od = out_data;
            if (in_ready != '0) begin
                gi = 99;
                if ($onehot(in_ready)) begin
                    for (int i = 0; i < NREQ; i++) if (in_ready[i]) gi = i;
                end
                gpos_q.push_back(bits_q.size());
                grants_q.push_back(gi);
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int exp_bit(input int src, input logic [7:0] d, input int k);
        if (k < IDB) return (src >> k) & 1;
        return int'((d >> (k - IDB)) & 8'h01);
    endfunction

    task automatic wait_bits(input int n, input int limit, input string tag);
        int t = 0;
        while (bits_q.size() < n && t < limit) begin
            tick();
            t++;
        end
        if (bits_q.size() < n) check({tag, "_timeout"}, bits_q.size(), n);
    endtask

    task automatic wait_grants(input int n, input int limit, input string tag);
        int t = 0;
        while (grants_q.size() < n && t < limit) begin
            tick();
            t++;
        end
        if (grants_q.size() < n) check({tag, "_timeout"}, grants_q.size(), n);
    endtask

    task automatic check_word(input string tag, input int base, input int src, input logic [7:0] d);
        for (int k = 0; k < WB; k++) begin
            check($sformatf("%s_bit%0d", tag, k), qget(bits_q, base + k), exp_bit(src, d, k));
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_valid   = '0;
        ack_freeze = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        int bb;
        int gb;
        logic [1:0] od;
        logic [7:0] bdat [NREQ];

        in_data = '0;
        do_reset();
        check("rst_out_data", int'(out_data), 0);
        check("rst_in_ready", int'(in_ready), 0);

        // Single word 0xA5 from source 1.
        in_data[1] = 8'hA5;
        in_valid   = 3'b010;
        bb = bits_q.size();
        gb = grants_q.size();
        reset = 1'b0;
        wait_grants(gb + 1, 50, "a_grant");
        in_valid = '0;
        wait_bits(bb + WB, 600, "a_bits");
        repeat (30) tick();
        check("a_grant_count", grants_q.size() - gb, 1);
        check("a_grant_idx", qget(grants_q, gb), 1);
        check_word("a", bb, 1, 8'hA5);
        check("a_bit_total", bits_q.size() - bb, WB);
        od = 2'b00;
        for (int k = 0; k < WB; k++) od ^= (exp_bit(1, 8'hA5, k) != 0) ? 2'b10 : 2'b01;
        check("a_out_data", int'(out_data), int'(od));
        check("a_violations", viol, 0);

        // All sources continuously valid: 0,1,2,0,1,2.
        do_reset();
        bdat[0] = 8'h01; bdat[1] = 8'h80; bdat[2] = 8'hC3;
        for (int i = 0; i < NREQ; i++) in_data[i] = bdat[i];
        in_valid = 3'b111;
        bb = bits_q.size();
        gb = grants_q.size();
        reset = 1'b0;
        wait_grants(gb + 6, 1500, "b_grants");
        in_valid = '0;
        wait_bits(bb + 6 * WB, 1500, "b_bits");
        repeat (30) tick();
        check("b_grant_count", grants_q.size() - gb, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("b_grant%0d", i), qget(grants_q, gb + i), i % 3);
            check($sformatf("b_gpos%0d", i), qget(gpos_q, gb + i) - bb, i * WB);
            check_word($sformatf("b_w%0d", i), bb + i * WB, i % 3, bdat[i % 3]);
        end
        check("b_violations", viol, 0);

        // Ack frozen after the first toggle: link stalls, no further grants.
        do_reset();
        ack_freeze = 1'b1;
        in_data[0] = 8'h5A;
        in_valid   = 3'b001;
        bb = bits_q.size();
        gb = grants_q.size();
        reset = 1'b0;
        wait_grants(gb + 1, 50, "c_grant");
        in_valid = 3'b110;
        repeat (120) tick();
        check("c_bit_count", bits_q.size() - bb, 1);
        check("c_first_bit", qget(bits_q, bb), exp_bit(0, 8'h5A, 0));
        check("c_out_data", int'(out_data), (exp_bit(0, 8'h5A, 0) != 0) ? 2 : 1);
        check("c_grant_count", grants_q.size() - gb, 1);
        check("c_in_ready", int'(in_ready), 0);

        // Reset after the third bit abandons the word; source 0 wins afterwards.
        do_reset();
        in_data[1] = 8'h96;
        in_valid   = 3'b010;
        bb = bits_q.size();
        gb = grants_q.size();
        reset = 1'b0;
        wait_grants(gb + 1, 50, "d_grant");
        in_valid = '0;
        wait_bits(bb + 3, 200, "d_bits");
        reset    = 1'b1;
        in_valid = 3'b111;
        tick();
        check("d_out_data_rst", int'(out_data), 0);
        check("d_in_ready_rst", int'(in_ready), 0);
        repeat (4) tick();
        check("d_in_ready_hold", int'(in_ready), 0);
        check("d_bits_abandoned", bits_q.size() - bb, 3);
        reset = 1'b0;
        #1;
        check("d_in_ready_rel", int'(in_ready), 1);
        tick();
        check("d_first_grant", qget(grants_q, gb + 1), 0);
        in_valid = '0;

        // Source 0 drops while source 1 rises during a busy word; payload immune.
        do_reset();
        in_data[2] = 8'h0F;
        in_data[1] = 8'h3C;
        in_valid   = 3'b100;
        bb = bits_q.size();
        gb = grants_q.size();
        reset = 1'b0;
        wait_grants(gb + 1, 50, "e_grant0");
        in_valid   = 3'b001;
        in_data[2] = 8'hFF;
        repeat (5) tick();
        in_valid = 3'b010;
        wait_grants(gb + 2, 600, "e_grant1");
        in_valid = '0;
        wait_bits(bb + 2 * WB, 800, "e_bits");
        repeat (30) tick();
        check("e_grant_count", grants_q.size() - gb, 2);
        check("e_grant0", qget(grants_q, gb), 2);
        check("e_grant1", qget(grants_q, gb + 1), 1);
        check_word("e_w0", bb, 2, 8'h0F);
        check_word("e_w1", bb + WB, 1, 8'h3C);
        check("e_violations", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
